// File: rtl/spi_pkg.sv
// Shared constants for the SPI peripheral shift path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

    // Bit-order encodings carried by lsbFirst / modeLsb.
    localparam logic SPI_MSB_FIRST = 1'b0;
    localparam logic SPI_LSB_FIRST = 1'b1;

    // Word width used when the parent does not override it.
    localparam int SPI_DEFAULT_WIDTH = 8;

endpackage : spi_pkg

// File: rtl/spi_bit_counter.sv
// Modulo-width bit counter with synchronous clear and a terminal-count flag.
// Latency: count updates one clk after enable; terminal is combinational.
// Backpressure: none; clear has priority over enable.
module spi_bit_counter
    import spi_pkg::*;
#(
    parameter int width = SPI_DEFAULT_WIDTH,
    localparam int countWidth = $clog2(width)
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  clear,
    input  logic                  enable,
    output logic [countWidth-1:0] count,
    output logic                  terminal
);

    localparam logic [countWidth-1:0] LAST = countWidth'(width - 1);

    // Terminal fires on the shift that brings the word to full width.
    assign terminal = enable && !clear && (count == LAST);

    // Counter register: clear wins, otherwise step and wrap at width-1.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + countWidth'(1);
            end
        end
    end

endmodule : spi_bit_counter

// File: rtl/spi_shift_engine.sv
// SPI shift register with bit counting and a received-word holding register.
// Latency: shift, wordDone, rxData and rxValid all update on the strobe's clk edge.
// Backpressure: none; a completed word overwrites unacked rxData and sets sticky overrun.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int width = SPI_DEFAULT_WIDTH,
    localparam int countWidth = $clog2(width)
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             chipSelectN,
    input  logic             peripheralClkEdge,
    input  logic             lsbFirst,
    input  logic             parallelLoad,
    input  logic [width-1:0] parallelDataIn,
    input  logic             serialDataIn,
    output logic             serialDataOut,
    output logic [width-1:0] parallelDataOut,
    output logic             wordDone,
    output logic [width-1:0] rxData,
    output logic             rxValid,
    input  logic             rxAck,
    output logic             overrun,
    input  logic             clearOverrun
);

    logic [width-1:0]      shiftReg;
    logic [width-1:0]      shiftNext;
    logic                  modeLsb;
    logic                  shiftEn;
    logic                  counterClear;
    logic                  complete;
    logic [countWidth-1:0] bitCount;

    // Load beats deselect, deselect beats the strobe.
    assign counterClear = parallelLoad || chipSelectN;
    assign shiftEn      = !counterClear && peripheralClkEdge;

    spi_bit_counter #(
        .width (width)
    ) u_bit_counter (
        .clk      (clk),
        .resetN   (resetN),
        .clear    (counterClear),
        .enable   (shiftEn),
        .count    (bitCount),
        .terminal (complete)
    );

    // Next shift value: MSB-first shifts left, LSB-first shifts right.
    always_comb begin
        shiftNext = shiftReg;
        if (modeLsb == SPI_LSB_FIRST) begin
            shiftNext = {serialDataIn, shiftReg[width-1:1]};
        end else begin
            shiftNext = {shiftReg[width-2:0], serialDataIn};
        end
    end

    // Shift register and bit-order mode; order is latched only on load.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            shiftReg <= '0;
            modeLsb  <= SPI_MSB_FIRST;
        end else if (parallelLoad) begin
            shiftReg <= parallelDataIn;
            modeLsb  <= lsbFirst;
        end else if (shiftEn) begin
            shiftReg <= shiftNext;
        end
    end

    // Word completion pulse and capture of the full word including the last bit.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wordDone <= 1'b0;
            rxData   <= '0;
        end else begin
            wordDone <= complete;
            if (complete) begin
                rxData <= shiftNext;
            end
        end
    end

    // Valid flag: completion sets it even if acked in the same cycle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rxValid <= 1'b0;
        end else if (complete) begin
            rxValid <= 1'b1;
        end else if (rxAck) begin
            rxValid <= 1'b0;
        end
    end

    // Sticky overrun: an unacked word being overwritten; set beats clear.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            overrun <= 1'b0;
        end else if (complete && rxValid && !rxAck) begin
            overrun <= 1'b1;
        end else if (clearOverrun) begin
            overrun <= 1'b0;
        end
    end

    assign serialDataOut   = (modeLsb == SPI_LSB_FIRST) ? shiftReg[0] : shiftReg[width-1];
    assign parallelDataOut = shiftReg;

endmodule : spi_shift_engine

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine: directed scenarios plus random traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_shift_engine;

    localparam int W = 8;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         resetN = 1'b0;
    logic         chipSelectN = 1'b1;
    logic         peripheralClkEdge = 1'b0;
    logic         lsbFirst = 1'b0;
    logic         parallelLoad = 1'b0;
    logic [W-1:0] parallelDataIn = '0;
    logic         serialDataIn = 1'b0;
    logic         serialDataOut;
    logic [W-1:0] parallelDataOut;
    logic         wordDone;
    logic [W-1:0] rxData;
    logic         rxValid;
    logic         rxAck = 1'b0;
    logic         overrun;
    logic         clearOverrun = 1'b0;

    int checks = 0;
    int failures = 0;
    int doneCnt = 0;
    bit runCmp = 1'b0;

    spi_shift_engine #(.width(W)) dut (
        .clk               (clk),
        .resetN            (resetN),
        .chipSelectN       (chipSelectN),
        .peripheralClkEdge (peripheralClkEdge),
        .lsbFirst          (lsbFirst),
        .parallelLoad      (parallelLoad),
        .parallelDataIn    (parallelDataIn),
        .serialDataIn      (serialDataIn),
        .serialDataOut     (serialDataOut),
        .parallelDataOut   (parallelDataOut),
        .wordDone          (wordDone),
        .rxData            (rxData),
        .rxValid           (rxValid),
        .rxAck             (rxAck),
        .overrun           (overrun),
        .clearOverrun      (clearOverrun)
    );

    always #5 clk = ~clk;

    // Reference model: word as an integer, bits counted as shifted so far.
    int unsigned mWord = 0;
    bit          mLsb = 0;
    int          mBits = 0;
    bit          mDone = 0;
    int unsigned mRx = 0;
    bit          mVld = 0;
    bit          mOvr = 0;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mWord = 0; mLsb = 0; mBits = 0; mDone = 0; mRx = 0; mVld = 0; mOvr = 0;
        end else begin
            bit finished;
            finished = 0;
            if (parallelLoad) begin
                mWord = parallelDataIn;
                mLsb  = lsbFirst;
                mBits = 0;
            end else if (chipSelectN) begin
                mBits = 0;
            end else if (peripheralClkEdge) begin
                if (mLsb) mWord = (mWord / 2) + (serialDataIn ? (1 << (W - 1)) : 0);
                else      mWord = ((mWord * 2) + serialDataIn) & MASK;
                mBits = mBits + 1;
                if (mBits == W) begin
                    mBits = 0;
                    finished = 1;
                end
            end
            mDone = finished;
            if (finished) begin
                if (mVld && !rxAck) mOvr = 1;
                else if (clearOverrun) mOvr = 0;
                mRx  = mWord;
                mVld = 1;
            end else begin
                if (rxAck) mVld = 0;
                if (clearOverrun) mOvr = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (runCmp) begin
            check("m_sdo",  32'(serialDataOut),   32'(mLsb ? (mWord & 1) : ((mWord >> (W - 1)) & 1)));
            check("m_pdo",  32'(parallelDataOut), mWord);
            check("m_done", 32'(wordDone),        32'(mDone));
            check("m_rx",   32'(rxData),          mRx);
            check("m_vld",  32'(rxValid),         32'(mVld));
            check("m_ovr",  32'(overrun),         32'(mOvr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] val, input logic lsb);
        parallelLoad = 1'b1; parallelDataIn = val; lsbFirst = lsb;
        tick();
        parallelLoad = 1'b0;
    endtask

    task automatic strobe(input logic b);
        peripheralClkEdge = 1'b1; serialDataIn = b;
        tick();
        peripheralClkEdge = 1'b0;
        doneCnt += int'(wordDone);
    endtask

    // Shift a word, recording the transmit bit visible before each strobe.
    task automatic shift_word(input logic [W-1:0] bitsIn, output logic [W-1:0] seen);
        seen = '0;
        for (int i = W - 1; i >= 0; i--) begin
            seen = {seen[W-2:0], serialDataOut};
            strobe(bitsIn[i]);
        end
    endtask

    initial begin
        logic [W-1:0] seq;
        #12;
        resetN = 1'b1;
        runCmp = 1'b1;
        chipSelectN = 1'b0;

        // Idle after reset: nothing moves.
        repeat (3) tick();
        check("idle_pdo", 32'(parallelDataOut), 32'h0);
        check("idle_vld", 32'(rxValid), 32'h0);

        // MSB-first word.
        load(8'hA5, 1'b0);
        doneCnt = 0;
        shift_word(8'b1011_0010, seq);
        check("msb_sdo_seq", 32'(seq), 32'hA5);
        check("msb_rx", 32'(rxData), 32'hB2);
        check("msb_done_cnt", 32'(doneCnt), 32'd1);
        tick();
        check("done_one_cycle", 32'(wordDone), 32'h0);
        rxAck = 1'b1; tick(); rxAck = 1'b0;
        check("ack_clears", 32'(rxValid), 32'h0);

        // LSB-first word, bits listed in arrival order 0,1,0,0,1,1,0,1.
        load(8'hA5, 1'b1);
        shift_word(8'b0100_1101, seq);
        check("lsb_sdo_seq", 32'(seq), 32'hA5);
        check("lsb_rx", 32'(rxData), 32'hB2);

        // Second word with no ack -> overrun.
        load(8'h00, 1'b0);
        shift_word(8'h5A, seq);
        check("ovr_vld", 32'(rxValid), 32'h1);
        check("ovr_set", 32'(overrun), 32'h1);
        check("ovr_rx", 32'(rxData), 32'h5A);
        rxAck = 1'b1; tick(); rxAck = 1'b0;
        check("ovr_ack_vld", 32'(rxValid), 32'h0);
        check("ovr_sticky", 32'(overrun), 32'h1);
        clearOverrun = 1'b1; tick(); clearOverrun = 1'b0;
        check("ovr_clear", 32'(overrun), 32'h0);

        // Abort after 5 bits, then a full word gives one completion.
        load(8'h00, 1'b0);
        doneCnt = 0;
        repeat (5) strobe(1'b1);
        chipSelectN = 1'b1; tick();
        strobe(1'b0);
        check("abort_keep", 32'(parallelDataOut), 32'h1F);
        chipSelectN = 1'b0;
        for (int i = 0; i < 7; i++) strobe(1'b0);
        check("abort_no_done", 32'(doneCnt), 32'd0);
        strobe(1'b1);
        check("abort_one_done", 32'(doneCnt), 32'd1);
        check("abort_rx", 32'(rxData), 32'h01);

        // Load with a simultaneous strobe: load wins, count restarts.
        parallelLoad = 1'b1; parallelDataIn = 8'h81; lsbFirst = 1'b0;
        peripheralClkEdge = 1'b1; serialDataIn = 1'b0;
        tick();
        parallelLoad = 1'b0; peripheralClkEdge = 1'b0;
        check("ld_wins", 32'(parallelDataOut), 32'h81);
        doneCnt = 0;
        for (int i = 0; i < 7; i++) strobe(1'b1);
        check("ld_cnt_zero", 32'(doneCnt), 32'd0);
        // Completion together with ack: still valid, no overrun.
        rxAck = 1'b1; strobe(1'b1); rxAck = 1'b0;
        check("cmp_ack_vld", 32'(rxValid), 32'h1);
        check("cmp_ack_ovr", 32'(overrun), 32'h0);
        check("cmp_ack_rx", 32'(rxData), 32'hFF);

        // Asynchronous reset mid-word.
        load(8'hC3, 1'b1);
        strobe(1'b1);
        #3;
        resetN = 1'b0;
        #1;
        check("rst_pdo", 32'(parallelDataOut), 32'h0);
        check("rst_sdo", 32'(serialDataOut), 32'h0);
        check("rst_rx", 32'(rxData), 32'h0);
        check("rst_vld", 32'(rxValid), 32'h0);
        check("rst_done", 32'(wordDone), 32'h0);
        #10;
        resetN = 1'b1;
        repeat (3) tick();
        check("post_rst_pdo", 32'(parallelDataOut), 32'h0);
        check("post_rst_ovr", 32'(overrun), 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            parallelLoad      = ($urandom_range(0, 39) == 0);
            parallelDataIn    = W'($urandom);
            lsbFirst          = $urandom_range(0, 1) == 1;
            chipSelectN       = ($urandom_range(0, 29) == 0);
            peripheralClkEdge = ($urandom_range(0, 2) != 0);
            serialDataIn      = $urandom_range(0, 1) == 1;
            rxAck             = ($urandom_range(0, 9) == 0);
            clearOverrun      = ($urandom_range(0, 14) == 0);
            tick();
        end
        parallelLoad = 1'b0; peripheralClkEdge = 1'b0; rxAck = 1'b0; clearOverrun = 1'b0;
        tick();
        runCmp = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_spi_shift_engine

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
Parametrised successor to the SPI shift register. Shifts serial data in and out on peripheral clock-edge strobes, with MSB-first or LSB-first ordering. Counts bits per word, pulses on word completion, and hands each received word to a holding register with a valid/ack handshake and overrun detection. Sits between the SPI edge detector / input conditioner and the register-file / FSM layer of the SPI peripheral.

Parameters:
width, 8, shift/word width in bits (>= 2)
countWidth, $clog2(width), bit-counter width (derived; not overridden)

Ports:
clk  input  1  system clock; all state updates on rising edge
resetN  input  1  asynchronous, active-low reset
chipSelectN  input  1  active-low frame select; high aborts/idles the frame
peripheralClkEdge  input  1  one-cycle strobe (clk domain); shift when high
lsbFirst  input  1  bit-order select; captured on parallelLoad
parallelLoad  input  1  load parallelDataIn into shift register
parallelDataIn  input  width  transmit word
serialDataIn  input  1  serial receive bit (conditioned MOSI/MISO)
serialDataOut  output  1  current transmit bit
parallelDataOut  output  width  live shift-register contents
wordDone  output  1  one-cycle pulse: width bits shifted
rxData  output  width  last completed received word
rxValid  output  1  rxData holds an unconsumed word
rxAck  input  1  consumer acknowledge; clears rxValid
overrun  output  1  sticky: word completed while rxValid=1 and no rxAck
clearOverrun  input  1  clears overrun

Behaviour:
- Clock/reset fixed: single clock clk; resetN asynchronous, active-low.
- Reset values: shiftReg=0, bitCount=0, modeLsb=0, wordDone=0, rxData=0, rxValid=0, overrun=0; thus serialDataOut=0, parallelDataOut=0.
- Per-cycle priority: parallelLoad > chipSelectN high > peripheralClkEdge.
- parallelLoad=1: shiftReg<=parallelDataIn, modeLsb<=lsbFirst, bitCount<=0; any simultaneous strobe ignored; no wordDone.
- chipSelectN=1 (no load): bitCount<=0; strobes ignored; shiftReg retained; partial word discarded, no wordDone.
- Strobe shift (chipSelectN=0): modeLsb=0 -> shiftReg<={shiftReg[width-2:0],serialDataIn}; modeLsb=1 -> shiftReg<={serialDataIn,shiftReg[width-1:1]}.
- Each shift increments bitCount; on bitCount==width-1 the counter wraps to 0. In that same edge: wordDone<=1 for exactly one cycle; rxData<=new shiftReg value (including the bit being shifted in).
- serialDataOut combinational: modeLsb ? shiftReg[0] : shiftReg[width-1].
- parallelDataOut = shiftReg, combinational.
- Handshake on word completion: rxValid<=1. If rxValid was 1 and rxAck=0 in that cycle, overrun<=1 and rxData is overwritten. Completion + rxAck in the same cycle: rxValid stays 1, no overrun.
- rxAck with no completion clears rxValid; rxAck while rxValid=0 has no effect.
- overrun is sticky until clearOverrun=1 or reset. If set and clear coincide, set wins.
- Back-to-back words: continue strobing without reload; the next word shifts out the received bits, allowing echo/daisy-chain operation.
- Reset mid-word: everything returns to reset values immediately, independent of clk.

Decomposition:
- Shared package spi_pkg: constants SPI_MSB_FIRST=0 and SPI_LSB_FIRST=1, default width.
- One sub-module is natural: spi_bit_counter (modulo-width counter with clear/enable/terminal-count output) feeding the wordDone/rxValid logic.

Test Plan:
- Reset then idle: resetN=0 mid-run -> all outputs 0 asynchronously; after release with no strobes, outputs remain 0.
- MSB-first load/shift: load 8'hA5 with lsbFirst=0, then 8 strobes with serialDataIn=1,0,1,1,0,0,1,0 -> serialDataOut sequence 1,0,1,0,0,1,0,1; rxData=8'hB2; wordDone pulses once, after the 8th strobe.
- LSB-first: load 8'hA5 with lsbFirst=1, then 8 strobes with serialDataIn=0,1,0,0,1,1,0,1 -> serialDataOut sequence 1,0,1,0,0,1,0,1; rxData=8'hB2.
- Handshake/overrun: complete two words without rxAck -> rxValid=1, overrun=1, rxData=second word. Then rxAck -> rxValid=0 with overrun still 1. Then clearOverrun -> overrun=0.
- Abort: chipSelectN=1 after 5 strobes -> no wordDone; after reselect, 8 further strobes produce exactly one wordDone.
- Simultaneous events: parallelLoad together with a strobe -> load wins, bitCount=0. Completion together with rxAck -> rxValid stays 1, no overrun.
